led_afterglow: RTL and testbench



---
 rtl/led_afterglow_pkg.sv | 16 +
 rtl/led_afterglow_if.sv | 27 ++
 rtl/led_afterglow_channel.sv | 55 +++++
 rtl/led_afterglow.sv | 60 ++++++
 tb/tb_led_afterglow.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/led_afterglow_pkg.sv
// Shared constants and types for the LED afterglow output stage.
// Brightness is a BW-bit level; full scale means solid on.
package afterglow_pkg;

  localparam int NLED     = 8;
  localparam int BW       = 4;
  localparam int BMAX     = (1 << BW) - 1;
  localparam int PRE_BASE = 6;
  localparam int PRE_W    = 21;

  typedef logic [BW-1:0] bright_t;

  localparam logic DECAY_LIN = 1'b0;
  localparam logic DECAY_EXP = 1'b1;

endpackage

// File: rtl/led_afterglow_if.sv
// Pattern/control bundle between the blinky generator and the afterglow stage.
interface led_afterglow_if;
  import afterglow_pkg::*;

  logic [NLED-1:0] pattern_in;
  logic [3:0]      decay_sel;
  logic            decay_mode;
  logic            bypass;
  logic [NLED-1:0] led_out;

  modport master (
    output pattern_in,
    output decay_sel,
    output decay_mode,
    output bypass,
    input  led_out
  );

  modport slave (
    input  pattern_in,
    input  decay_sel,
    input  decay_mode,
    input  bypass,
    output led_out
  );

endinterface

// File: rtl/led_afterglow_channel.sv
// One LED: brightness register with load/decay, PWM compare and registered pin drive.
module afterglow_channel
  import afterglow_pkg::*;
(
  input  logic    clk25,
  input  logic    rst,
  input  logic    load,
  input  logic    tick,
  input  logic    decay_mode,
  input  bright_t pwm_cnt,
  input  logic    bypass,
  output logic    led
);

  localparam bright_t B_FULL = bright_t'(BMAX);
  localparam bright_t B_ZERO = {BW{1'b0}};
  localparam bright_t B_ONE  = {{(BW-1){1'b0}}, 1'b1};

  bright_t b_r;
  bright_t b_nxt_s;
  logic    on_s;
  logic    led_r;

  // Next brightness (load beats decay) and the compare against it, so the pin
  // reflects a new level in the same edge the level is stored.
  always_comb begin
    b_nxt_s = b_r;
    if (load) begin
      b_nxt_s = B_FULL;
    end else if (tick && (b_r != B_ZERO)) begin
      if (decay_mode == DECAY_EXP) begin
        b_nxt_s = b_r >> 1;
      end else begin
        b_nxt_s = b_r - B_ONE;
      end
    end else begin
      b_nxt_s = b_r;
    end
    on_s = (b_nxt_s == B_FULL) || (pwm_cnt < b_nxt_s);
  end

  // Brightness state and pin register; brightness keeps tracking during bypass.
  always_ff @(posedge clk25) begin
    if (rst) begin
      b_r   <= B_ZERO;
      led_r <= 1'b0;
    end else begin
      b_r   <= b_nxt_s;
      led_r <= bypass ? load : on_s;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_afterglow.sv
// Afterglow output stage: registers the generator pattern, runs the shared decay
// prescaler and PWM counter, and drives one afterglow_channel per LED.
module led_afterglow #(
  parameter int NLED     = afterglow_pkg::NLED,
  parameter int BW       = afterglow_pkg::BW,
  parameter int PRE_W    = afterglow_pkg::PRE_W,
  parameter int PRE_BASE = afterglow_pkg::PRE_BASE
) (
  input  logic            clk25,
  input  logic            rst,
  led_afterglow_if.slave  bus
);

  localparam int SH_W = $clog2(PRE_W + 1);

  logic [NLED-1:0]  pattern_q_r;
  logic [PRE_W-1:0] pre_r;
  logic [BW-1:0]    pwm_cnt_r;
  logic [SH_W-1:0]  shamt_s;
  logic [PRE_W-1:0] mask_s;
  logic             tick_s;
  logic [NLED-1:0]  led_s;

  // Input register, free-running decay prescaler and PWM counter.
  always_ff @(posedge clk25) begin
    if (rst) begin
      pattern_q_r <= {NLED{1'b0}};
      pre_r       <= {PRE_W{1'b0}};
      pwm_cnt_r   <= {BW{1'b0}};
    end else begin
      pattern_q_r <= bus.pattern_in;
      pre_r       <= pre_r + PRE_W'(1'b1);
      pwm_cnt_r   <= pwm_cnt_r + BW'(1'b1);
    end
  end

  // Tick when the low decay_sel+PRE_BASE prescaler bits are all ones; the
  // all-ones wrap therefore ticks for every speed setting.
  always_comb begin
    shamt_s = SH_W'(bus.decay_sel) + SH_W'(PRE_BASE);
    mask_s  = ~({PRE_W{1'b1}} << shamt_s);
    tick_s  = ((pre_r & mask_s) == mask_s);
  end

  for (genvar gi = 0; gi < NLED; gi++) begin : g_ch
    afterglow_channel u_ch (
      .clk25      (clk25),
      .rst        (rst),
      .load       (pattern_q_r[gi]),
      .tick       (tick_s),
      .decay_mode (bus.decay_mode),
      .pwm_cnt    (pwm_cnt_r),
      .bypass     (bus.bypass),
      .led        (led_s[gi])
    );
  end

  assign bus.led_out = led_s;

endmodule

// File: tb/tb_led_afterglow.sv
// Directed bench for led_afterglow: a per-cycle reference model feeds a queue of
// expected pin values, plus duty/latency checks against fixed expectations.
module tb_led_afterglow;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  led_afterglow_if bus();

  led_afterglow dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  // reference state, mirroring the registers as seen before the next edge
  logic [7:0]  m_q   = 8'h00;
  logic [20:0] m_pre = 21'd0;
  logic [3:0]  m_pwm = 4'd0;
  logic [3:0]  m_b [8];
  logic [7:0]  m_led = 8'h00;
  logic [7:0]  sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] nb;
    logic [7:0] nl;
    bit tk;
    int k;
    nl = 8'h00;
    if (rst) begin
      m_q = 8'h00; m_pre = 21'd0; m_pwm = 4'd0; m_led = 8'h00;
      for (int i = 0; i < 8; i++) m_b[i] = 4'd0;
    end else begin
      k  = int'(bus.decay_sel) + 6;
      tk = (((int'(m_pre) + 1) % (1 << k)) == 0);
      for (int i = 0; i < 8; i++) begin
        if (m_q[i]) nb = 4'd15;
        else if (tk && m_b[i] != 4'd0) nb = bus.decay_mode ? (m_b[i] >> 1) : (m_b[i] - 4'd1);
        else nb = m_b[i];
        nl[i] = bus.bypass ? m_q[i] : ((nb == 4'd15) || (m_pwm < nb));
        m_b[i] = nb;
      end
      m_led = nl;
      m_q   = bus.pattern_in;
      m_pre = m_pre + 21'd1;
      m_pwm = m_pwm + 4'd1;
    end
    sb_q.push_back(m_led);
  endtask

  task automatic step();
    logic [7:0] exp_v;
    model_edge();
    @(posedge clk25);
    #1;
    exp_v = sb_q.pop_front();
    chk("led_out_cycle", 32'(bus.led_out), 32'(exp_v));
  endtask

  task automatic count_win(input int n, input int idx, output int cnt);
    cnt = 0;
    for (int s = 0; s < n; s++) begin
      step();
      if (bus.led_out[idx] === 1'b1) cnt++;
    end
  endtask

  task automatic align(input int ph);
    while (m_pre[5:0] != 6'(ph)) step();
  endtask

  initial begin
    int cnt;
    int nz;
    int found;
    int waited;
    int exp_seq [4];
    exp_seq = '{7, 3, 1, 0};
    for (int i = 0; i < 8; i++) m_b[i] = 4'd0;
    bus.pattern_in = 8'hFF;
    bus.decay_sel  = 4'd0;
    bus.decay_mode = 1'b0;
    bus.bypass     = 1'b0;
    rst = 1'b1;

    // reset held with all LEDs requested
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_led_zero", 32'(bus.led_out), 32'(8'h00));
    end
    rst = 1'b0;
    step();
    chk("release_edge1", 32'(bus.led_out), 32'(8'h00));
    step();
    chk("release_edge2", 32'(bus.led_out), 32'(8'hFF));

    // reset in the middle of a fade leaves nothing behind
    bus.pattern_in = 8'h00;
    repeat (100) step();
    rst = 1'b1;
    step();
    chk("reset_midfade", 32'(bus.led_out), 32'(8'h00));
    rst = 1'b0;
    nz = 0;
    repeat (32) begin
      step();
      if (bus.led_out !== 8'h00) nz++;
    end
    chk("no_trail_after_reset", 32'(nz), 32'(0));

    // linear fade of LED0, duty measured over tick-aligned 64-clock windows
    align(10);
    bus.pattern_in = 8'h01;
    step();
    bus.pattern_in = 8'h00;
    align(47);
    count_win(16, 0, cnt);
    chk("lin_solid_full", 32'(cnt), 32'(16));
    for (int t = 0; t < 15; t++) begin
      count_win(64, 0, cnt);
      chk($sformatf("lin_duty_step%0d", t), 32'(cnt), 32'(4 * (14 - t)));
    end

    // exponential fade 15,7,3,1,0
    bus.decay_mode = 1'b1;
    align(10);
    bus.pattern_in = 8'h01;
    step();
    bus.pattern_in = 8'h00;
    align(47);
    count_win(16, 0, cnt);
    chk("exp_solid_full", 32'(cnt), 32'(16));
    for (int t = 0; t < 4; t++) begin
      count_win(64, 0, cnt);
      chk($sformatf("exp_duty_step%0d", t), 32'(cnt), 32'(4 * exp_seq[t]));
    end

    // load held across a tick keeps LED3 solid
    bus.decay_mode = 1'b0;
    bus.pattern_in = 8'h08;
    step();
    step();
    align(60);
    count_win(64, 3, cnt);
    chk("load_vs_tick_solid", 32'(cnt), 32'(64));

    // bypass passes the registered pattern with 2-edge latency
    bus.bypass     = 1'b1;
    bus.pattern_in = 8'hA5;
    step();
    step();
    chk("bypass_latency", 32'(bus.led_out), 32'(8'hA5));
    nz = 0;
    repeat (20) begin
      step();
      if (bus.led_out !== 8'hA5) nz++;
    end
    chk("bypass_no_toggle", 32'(nz), 32'(0));
    bus.pattern_in = 8'h00;
    step();
    step();
    chk("bypass_follows_clear", 32'(bus.led_out), 32'(8'h00));
    repeat (10) step();
    bus.bypass = 1'b0;
    count_win(16, 0, cnt);
    chk("bypass_exit_resumes_pwm", 32'((cnt >= 13) && (cnt <= 16)), 32'(1));

    // slowest speed: no tick anywhere near; switching to fastest ticks quickly
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.decay_sel  = 4'd15;
    bus.pattern_in = 8'hFF;
    step();
    bus.pattern_in = 8'h00;
    step();
    nz = 0;
    repeat (200) begin
      step();
      if (bus.led_out === 8'hFF) nz++;
    end
    chk("sel15_no_tick", 32'(nz), 32'(200));
    bus.decay_sel = 4'd0;
    found  = 0;
    waited = 0;
    while (found == 0 && waited < 80) begin
      step();
      waited++;
      if (bus.led_out !== 8'hFF) found = 1;
    end
    chk("sel_change_tick_soon", 32'(found), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
